// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush control slice.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned PERF_W     = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DFREEZE = 2'd1,
        ST_IFREEZE = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX load and the ID source registers.
// Register x0 never produces a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    output logic                  o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // Match the load destination against each source the ID instruction reads
    always_comb begin
        w_rs1_hit  = i_id_rs1_used && (i_ex_rd == i_id_rs1);
        w_rs2_hit  = i_id_rs2_used && (i_ex_rd == i_id_rs2);
        o_load_use = i_ex_memread && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Stall/flush outputs are combinational; the freeze FSM, watchdog and perf
// counters are registered. Optional macro STALL_PERF_CNT_EN enables the
// perf counters; without it the perf ports read 0 and no counter flops exist.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  branch_taken_i,
    input  logic                  icache_stall_i,
    input  logic                  dcache_stall_i,
    output logic                  pc_write_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_stall_o,
    output logic                  mem_wb_stall_o,
    output logic [1:0]            state_o,
    output logic                  timeout_o,
    output logic [PERF_W-1:0]     stall_cycles_o,
    output logic [PERF_W-1:0]     bubble_cycles_o,
    output logic [PERF_W-1:0]     flush_cycles_o
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout;

    logic w_lu;
    logic w_freeze;
    logic w_bubble;
    logic w_flush_act;

    hazard_detect u_hazard_detect (
        .i_ex_memread  (ex_memread_i),
        .i_ex_rd       (ex_rd_i),
        .i_id_rs1      (id_rs1_i),
        .i_id_rs2      (id_rs2_i),
        .i_id_rs1_used (id_rs1_used_i),
        .i_id_rs2_used (id_rs2_used_i),
        .o_load_use    (w_lu)
    );

    // Priority decode: cache freeze > load-use bubble > branch flush
    always_comb begin
        w_freeze    = dcache_stall_i || icache_stall_i;
        w_bubble    = !w_freeze && w_lu;
        w_flush_act = !w_freeze && !w_lu && branch_taken_i;
    end

    // Combinational stall/flush drive; reset forces a full hold
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_stall_o = 1'b0;
        if (rst_i || w_freeze) begin
            pc_write_o     = 1'b0;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_stall_o = 1'b1;
        end else if (w_bubble) begin
            pc_write_o    = 1'b0;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (w_flush_act) begin
            if_id_flush_o = 1'b1;
        end
    end

    // Freeze FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Freeze FSM next state: a D-cache miss always wins over an I-cache miss
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN, ST_DFREEZE, ST_IFREEZE: begin
                if (dcache_stall_i) begin
                    w_state_next = ST_DFREEZE;
                end else if (icache_stall_i) begin
                    w_state_next = ST_IFREEZE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Watchdog counts freeze cycles, saturates, clears on return to RUN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wd_cnt <= '0;
        end else if (w_state_next == ST_RUN) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != LP_TIMEOUT) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, set on the freeze cycle that brings the count to TIMEOUT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if ((w_state_next != ST_RUN) && (r_wd_cnt >= LP_TIMEOUT_M1)) begin
            r_timeout <= 1'b1;
        end
    end

    assign state_o   = r_state;
    assign timeout_o = r_timeout;

`ifdef STALL_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_bubble_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    // Perf counters, free-running and wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_freeze)    r_stall_cnt  <= r_stall_cnt + 1'b1;
            if (w_bubble)    r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (w_flush_act) r_flush_cnt  <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cycles_o  = r_stall_cnt;
    assign bubble_cycles_o = r_bubble_cnt;
    assign flush_cycles_o  = r_flush_cnt;
`else
    assign stall_cycles_o  = '0;
    assign bubble_cycles_o = '0;
    assign flush_cycles_o  = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the Stall/Flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Sources: load-use hazards, branch redirects in ID, and I-cache/D-cache miss stalls.
- Tracks freeze episodes in a small FSM, with a watchdog that flags a memory stall that never ends.

Parameters:
- TIMEOUT, 1023: freeze cycles before timeout_o asserts.
- CNT_W, 10: watchdog counter width; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of EX instruction
- id_rs1_i  in  5  rs1 of ID instruction
- id_rs2_i  in  5  rs2 of ID instruction
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- branch_taken_i  in  1  ID resolved a taken branch/jump
- icache_stall_i  in  1  I-cache miss in progress
- dcache_stall_i  in  1  D-cache miss in progress
- pc_write_o  out  1  PC update enable
- if_id_stall_o  out  1  hold IF_ID
- if_id_flush_o  out  1  clear IF_ID
- id_ex_stall_o  out  1  hold ID_EX
- id_ex_flush_o  out  1  insert bubble into ID_EX
- ex_mem_stall_o  out  1  hold EX_MEM
- mem_wb_stall_o  out  1  hold MEM_WB
- state_o  out  2  FSM state (RUN=0, DFREEZE=1, IFREEZE=2)
- timeout_o  out  1  sticky watchdog flag
- stall_cycles_o  out  32  perf: freeze cycles
- bubble_cycles_o  out  32  perf: load-use bubbles
- flush_cycles_o  out  32  perf: IF_ID flushes

Behaviour:
- Stall/flush outputs are combinational from the inputs, so they take effect in the same cycle. FSM, watchdog and perf counters are registered.
- Reset (rst_i=1, async):
  - state=RUN, watchdog count=0, timeout_o=0, perf counters=0.
  - While rst_i=1: pc_write_o=0, all *_stall_o=1, all *_flush_o=0.
- Load-use hazard, lu:
  - lu = ex_memread_i & ex_rd_i!=0 & ((id_rs1_used_i & ex_rd_i==id_rs1_i) | (id_rs2_used_i & ex_rd_i==id_rs2_i)).
  - Register x0 never hazards.
- Priority, highest first:
  1. dcache_stall_i: full freeze. pc_write_o=0, all four *_stall_o=1, no flushes.
  2. icache_stall_i: full freeze, identical outputs.
  3. lu: pc_write_o=0, if_id_stall_o=1, id_ex_flush_o=1. EX_MEM and MEM_WB advance. branch_taken_i is ignored, because the branch re-resolves after the bubble.
  4. branch_taken_i: pc_write_o=1, if_id_flush_o=1. All other stages advance.
  5. None of the above: pc_write_o=1, everything else 0.
- Freeze suppresses flushes. Because ID is held, a branch seen during freeze is re-presented and acted on in the first non-freeze cycle.
- FSM, evaluated each clock:
  - RUN -> DFREEZE if dcache_stall_i; else -> IFREEZE if icache_stall_i.
  - DFREEZE -> RUN when dcache_stall_i=0; if icache_stall_i=1 in that cycle, -> IFREEZE instead.
  - IFREEZE -> DFREEZE if dcache_stall_i rises; -> RUN when both stall inputs are 0.
- Watchdog:
  - Counts +1 per cycle spent in DFREEZE or IFREEZE, saturating at TIMEOUT.
  - Cleared on entry to RUN.
  - When it reaches TIMEOUT, timeout_o=1 and holds until reset. Outputs are otherwise unaffected.
- Reset mid-freeze: immediate return to RUN with counters cleared. timeout_o clears only on reset.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - stall_cycles_o +1 per cycle in priority 1 or 2.
  - bubble_cycles_o +1 per priority-3 cycle.
  - flush_cycles_o +1 per priority-4 cycle.
  - All three wrap at 2^32 and reset to 0.
- Undefined: ports remain, tied to 0, no flops.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN/DFREEZE/IFREEZE, 2-bit), REG_ADDR_W=5, PERF_W=32.
- Sub-module hazard_detect: the combinational lu compare; reusable by the forwarding unit.

Test Plan:
- Load x5, ID reads rs1=x5 (used) -> one cycle of pc_write_o=0, if_id_stall_o=1, id_ex_flush_o=1, ex_mem_stall_o=0. Repeat with ex_rd_i=0 -> no stall.
- branch_taken_i=1 with lu=0 -> if_id_flush_o=1, pc_write_o=1. branch_taken_i=1 with lu=1 -> no flush, bubble only.
- dcache_stall_i high for 5 cycles with branch_taken_i=1 -> all stalls=1, no flush, state_o=1. Next cycle flush asserted and state_o=0.
- dcache_stall_i falls while icache_stall_i=1 -> state_o goes 1->2 with no RUN cycle. Freeze continuous.
- TIMEOUT=8, dcache_stall_i held 20 cycles -> timeout_o rises at the 8th freeze cycle and stays 1 after the stall ends. Async rst_i pulse clears it with no clock edge.
- With STALL_PERF_CNT_EN: 3 freeze cycles, 2 bubbles, 1 flush -> counters read 3/2/1. Without the macro, all read 0.
